// File: rtl/decode_stage.sv
// RV32I decode stage with the ID/EX pipeline register: register-file addressing,
// control/immediate decode, same-cycle writeback bypass and the registered execute-stage bundle.
module decode_stage #(
  parameter int              XLEN     = 32,  // only 32 is supported
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            valid_d,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            we3_w,
  input  logic [4:0]      a3_w,
  input  logic [XLEN-1:0] wd3_w,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic [1:0]      result_src_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            alu_src_a_e,
  output logic            alu_src_b_e,
  output logic [3:0]      alu_control_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic            illegal_e
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            branch;
    logic            jump;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            illegal;
  } idex_t;

  idex_t d, q;

  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (alt && is_r) ? ALU_SUB : ALU_ADD;  // no SUBI form exists
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rd1_byp, rd2_byp;

  assign opcode = instr_d[6:0];
  assign a1     = instr_d[19:15];
  assign a2     = instr_d[24:20];

  assign imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
  assign imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
  assign imm_u = {instr_d[31:12], 12'b0};
  assign imm_j = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

  // x0 reads as zero; a matching non-zero writeback this cycle overrides the stale file read.
  assign rd1_byp = (a1 == 5'd0) ? '0 : (we3_w && a3_w == a1) ? wd3_w : rd1;
  assign rd2_byp = (a2 == 5'd0) ? '0 : (we3_w && a3_w == a2) ? wd3_w : rd2;

  always_comb begin
    // NOTE: assigning every field up front keeps this block free of inferred latches.
    d             = '0;
    d.valid       = 1'b1;
    d.funct3      = instr_d[14:12];
    d.rd1         = rd1_byp;
    d.rd2         = rd2_byp;
    d.rs1         = a1;
    d.rs2         = a2;
    d.rd          = instr_d[11:7];
    d.pc          = pc_d;
    d.pc_plus4    = pc_plus4_d;
    d.alu_control = ALU_ADD;
    case (opcode)
      OP_R:      begin d.reg_write = 1'b1; d.alu_control = alu_from_funct3(instr_d[14:12], instr_d[30], 1'b1); end
      OP_IMM:    begin d.reg_write = 1'b1; d.alu_src_b = 1'b1; d.imm = imm_i;
                       d.alu_control = alu_from_funct3(instr_d[14:12], instr_d[30], 1'b0); end
      OP_LOAD:   begin d.reg_write = 1'b1; d.alu_src_b = 1'b1; d.imm = imm_i; d.result_src = 2'b01; end
      OP_STORE:  begin d.mem_write = 1'b1; d.alu_src_b = 1'b1; d.imm = imm_s; end
      OP_BRANCH: begin d.branch = 1'b1; d.alu_control = ALU_SUB; d.imm = imm_b; end
      OP_JAL:    begin d.reg_write = 1'b1; d.jump = 1'b1; d.alu_src_a = 1'b1; d.alu_src_b = 1'b1;
                       d.imm = imm_j; d.result_src = 2'b10; end
      OP_JALR:   begin d.reg_write = 1'b1; d.jump = 1'b1; d.alu_src_b = 1'b1;
                       d.imm = imm_i; d.result_src = 2'b10; end
      OP_LUI:    begin d.reg_write = 1'b1; d.alu_src_b = 1'b1; d.imm = imm_u; d.alu_control = ALU_PASSB; end
      OP_AUIPC:  begin d.reg_write = 1'b1; d.alu_src_a = 1'b1; d.alu_src_b = 1'b1; d.imm = imm_u; end
      default:   d.illegal = 1'b1;
    endcase
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    // A bubble only needs its side-effecting controls cleared; data fields ride along.
    if (flush_e || !valid_d) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_write = 1'b0;
      d.branch    = 1'b0;
      d.jump      = 1'b0;
      d.illegal   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      q.pc <= RESET_PC;
    end else if (flush_e || !stall_e) begin
      q <= d;
    end
  end

  assign valid_e       = q.valid;
  assign reg_write_e   = q.reg_write;
  assign mem_write_e   = q.mem_write;
  assign result_src_e  = q.result_src;
  assign branch_e      = q.branch;
  assign jump_e        = q.jump;
  assign alu_src_a_e   = q.alu_src_a;
  assign alu_src_b_e   = q.alu_src_b;
  assign alu_control_e = q.alu_control;
  assign funct3_e      = q.funct3;
  assign rd1_e         = q.rd1;
  assign rd2_e         = q.rd2;
  assign imm_e         = q.imm;
  assign rs1_e         = q.rs1;
  assign rs2_e         = q.rs2;
  assign rd_e          = q.rd;
  assign pc_e          = q.pc;
  assign pc_plus4_e    = q.pc_plus4;
  assign illegal_e     = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by random traffic
// compared against a mnemonic-level reference model of the ID/EX register.
module tb_decode_stage;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_d, pc_d, pc_plus4_d, rd1, rd2, wd3_w;
  logic        valid_d, we3_w, stall_e, flush_e;
  logic [4:0]  a1, a2, a3_w;
  logic        valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_a_e, alu_src_b_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_control_e;
  logic [2:0]  funct3_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .we3_w(we3_w), .a3_w(a3_w),
    .wd3_w(wd3_w), .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
    .branch_e(branch_e), .jump_e(jump_e), .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
    .alu_control_e(alu_control_e), .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .illegal_e(illegal_e)
  );

  typedef struct {
    logic        valid, reg_write, mem_write, branch, jump, illegal, src_a, src_b;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t cur;
  logic bub;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic [31:0] file_val,
                                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wa == idx) return wd;
    return file_val;
  endfunction

  // Reference decode: per-format immediates built arithmetically, ALU ops from a funct3 table.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd);
    exp_t e;
    logic [3:0] base_alu [8];
    logic [31:0] v;
    logic wr;
    base_alu = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    e = '{default: '0};
    e.valid = 1'b1;
    e.f3 = ins[14:12]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.rd1 = read_reg(ins[19:15], r1, we, wa, wd);
    e.rd2 = read_reg(ins[24:20], r2, we, wa, wd);
    e.pc = pc; e.pc4 = pc + 32'd4;
    wr = 1'b0;
    case (ins[6:0])
      7'h33, 7'h13: begin
        wr = 1'b1;
        e.src_b = (ins[6:0] == 7'h13);
        e.alu = base_alu[ins[14:12]];
        if (ins[14:12] == 3'd0 && ins[30] && ins[6:0] == 7'h33) e.alu = 4'd1;
        if (ins[14:12] == 3'd5 && ins[30]) e.alu = 4'd9;
        if (ins[6:0] == 7'h13) begin
          v = ins[31:20]; if (ins[31]) v = v - 32'd4096; e.imm = v;
        end
      end
      7'h03, 7'h67: begin
        wr = 1'b1; e.src_b = 1'b1;
        v = ins[31:20]; if (ins[31]) v = v - 32'd4096; e.imm = v;
        if (ins[6:0] == 7'h03) e.res = 2'd1; else begin e.res = 2'd2; e.jump = 1'b1; end
      end
      7'h23: begin
        e.mem_write = 1'b1; e.src_b = 1'b1;
        v = ins[31:25] * 32 + ins[11:7]; if (ins[31]) v = v - 32'd4096; e.imm = v;
      end
      7'h63: begin
        e.branch = 1'b1; e.alu = 4'd1;
        v = ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2; if (ins[31]) v = v - 32'd4096; e.imm = v;
      end
      7'h6F: begin
        wr = 1'b1; e.jump = 1'b1; e.src_a = 1'b1; e.src_b = 1'b1; e.res = 2'd2;
        v = ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2; if (ins[31]) v = v - 32'h0010_0000;
        e.imm = v;
      end
      7'h37: begin wr = 1'b1; e.src_b = 1'b1; e.alu = 4'd10; e.imm = ins & 32'hFFFF_F000; end
      7'h17: begin wr = 1'b1; e.src_a = 1'b1; e.src_b = 1'b1; e.imm = ins & 32'hFFFF_F000; end
      default: e.illegal = 1'b1;
    endcase
    e.reg_write = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  task automatic check_all();
    check("valid_e", valid_e, cur.valid);
    check("reg_write_e", reg_write_e, cur.reg_write);
    check("mem_write_e", mem_write_e, cur.mem_write);
    check("branch_e", branch_e, cur.branch);
    check("jump_e", jump_e, cur.jump);
    check("illegal_e", illegal_e, cur.illegal);
    if (!bub) begin
      check("result_src_e", result_src_e, cur.res);
      check("alu_src_a_e", alu_src_a_e, cur.src_a);
      check("alu_src_b_e", alu_src_b_e, cur.src_b);
      check("alu_control_e", alu_control_e, cur.alu);
      check("funct3_e", funct3_e, cur.f3);
      check("rd1_e", rd1_e, cur.rd1);
      check("rd2_e", rd2_e, cur.rd2);
      check("imm_e", imm_e, cur.imm);
      check("rs1_e", rs1_e, cur.rs1);
      check("rs2_e", rs2_e, cur.rs2);
      check("rd_e", rd_e, cur.rd);
      check("pc_e", pc_e, cur.pc);
      check("pc_plus4_e", pc_plus4_e, cur.pc4);
    end
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic vld,
                       input logic [31:0] r1, input logic [31:0] r2, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic stall, input logic flush);
    exp_t nxt;
    instr_d = ins; pc_d = pc; pc_plus4_d = pc + 32'd4; valid_d = vld;
    rd1 = r1; rd2 = r2; we3_w = we; a3_w = wa; wd3_w = wd; stall_e = stall; flush_e = flush;
    #1;
    check("a1", a1, ins[19:15]);
    check("a2", a2, ins[24:20]);
    nxt = model(ins, pc, r1, r2, we, wa, wd);
    if (flush || (!stall && !vld)) begin
      cur = nxt; bub = 1'b1;
      cur.valid = 0; cur.reg_write = 0; cur.mem_write = 0; cur.branch = 0; cur.jump = 0; cur.illegal = 0;
    end else if (!stall) begin
      cur = nxt; bub = 1'b0;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic expect_reset();
    cur = '{default: '0};
    cur.pc = RST_PC;
    bub = 1'b0;
    check_all();
  endtask

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] ins;
    logic [4:0]  wa;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    reset = 1'b0;
    instr_d = '0; pc_d = '0; pc_plus4_d = '0; valid_d = 1'b0; rd1 = '0; rd2 = '0;
    we3_w = 1'b0; a3_w = '0; wd3_w = '0; stall_e = 1'b0; flush_e = 1'b0;
    #12;
    expect_reset();
    reset = 1'b1;

    // addi x5,x1,-3
    apply(32'hFFD0_8293, 32'h100, 1, 32'd7, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    check("addi_alu", alu_control_e, 32'd0);
    check("addi_imm", imm_e, 32'hFFFF_FFFD);
    check("addi_rd", rd_e, 32'd5);
    check("addi_srcb", alu_src_b_e, 32'd1);

    // writeback bypass on rs1=x3, then x0 stays zero even with a3_w=0
    apply(32'h0001_8093, 32'h104, 1, 32'h11, 32'h0, 1, 5'd3, 32'h55, 0, 0);
    check("bypass_rs1", rd1_e, 32'h55);
    apply(32'h0000_0093, 32'h108, 1, 32'h11, 32'h0, 1, 5'd0, 32'h55, 0, 0);
    check("x0_zero", rd1_e, 32'h0);
    // add x1,x2,x4 with bypass on rs2
    apply(32'h0041_00B3, 32'h10C, 1, 32'h33, 32'h22, 1, 5'd4, 32'hABCD, 0, 0);
    check("bypass_rs2", rd2_e, 32'hABCD);

    // beq x0,x0,-8
    apply(32'hFE00_0CE3, 32'h110, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    check("beq_branch", branch_e, 32'd1);
    check("beq_imm", imm_e, 32'hFFFF_FFF8);
    check("beq_regw", reg_write_e, 32'd0);
    check("beq_alu", alu_control_e, 32'd1);

    // lw x6,8(x2), stalled twice, then flush wins over stall
    apply(32'h0081_2303, 32'h200, 1, 32'h40, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    apply(32'h0000_0013, 32'h204, 1, 32'h1, 32'h2, 0, 5'd0, 32'h0, 1, 0);
    check("stall1_rd", rd_e, 32'd6);
    apply(32'h0000_0013, 32'h208, 1, 32'h1, 32'h2, 0, 5'd0, 32'h0, 1, 0);
    check("stall2_res", result_src_e, 32'd1);
    apply(32'h0000_0013, 32'h20C, 1, 32'h1, 32'h2, 0, 5'd0, 32'h0, 1, 1);
    check("flush_valid", valid_e, 32'd0);

    // unknown opcode, a bubble via valid_d=0, and addi to x0
    apply(32'h0000_037F, 32'h300, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    check("illegal", illegal_e, 32'd1);
    check("illegal_valid", valid_e, 32'd1);
    apply(32'h0010_0313, 32'h304, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    check("bubble_valid", valid_e, 32'd0);
    apply(32'h0050_0013, 32'h308, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    check("rd0_regw", reg_write_e, 32'd0);

    for (int i = 0; i < 400; i++) begin
      ins = {$urandom(), 7'h00} | 32'(ops[$urandom_range(0, 9)]);
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom());
      wa = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom());
      apply(ins, $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 9) != 0), $urandom(), $urandom(),
            1'($urandom()), wa, $urandom(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
    end

    // asynchronous reset in the middle of a cycle with a valid instruction in EX
    apply(32'hFFD0_8293, 32'h400, 1, 32'd9, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    #2 reset = 1'b0;
    #1;
    expect_reset();
    #1 reset = 1'b1;
    apply(32'h0081_2303, 32'h500, 1, 32'h40, 32'h0, 0, 5'd0, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
